md5_round_ctrl: RTL

MD5_ROUND_CTRL -- requirements
Module: md5_round_ctrl

---
 rtl/md5_round_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/md5_round_ctrl.sv
// MD5 compression sequencer: walks one 512-bit block through INIT, 64 rounds,
// the final hash addition and a done pulse, and emits the per-round indices.
module md5_round_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       first_blk,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [5:0] cnt,
    output logic [3:0] g,
    output logic [1:0] fsel,
    output logic       load_abcd,
    output logic       iv_sel,
    output logic       round_en,
    output logic       add_en
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t     state, state_next;
    logic [5:0] cnt_q, cnt_next;
    logic       iv_flag, iv_flag_next;
    logic [3:0] cnt_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt_q   <= '0;
            iv_flag <= 1'b0;
        end else begin
            state   <= state_next;
            cnt_q   <= cnt_next;
            iv_flag <= iv_flag_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt_q;
        iv_flag_next = iv_flag;
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next   = INIT;
                    iv_flag_next = first_blk;
                end
            end
            INIT: begin
                state_next = ROUND;
                cnt_next   = '0;
            end
            ROUND: begin
                if (cnt_q == 6'd63) begin
                    state_next = FINAL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q + 6'd1;
                end
            end
            FINAL: begin
                state_next = DONE;
                cnt_next   = '0;
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // Cancel wins over every other transition, but only once a block is in flight.
        if (abort && state != IDLE) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        load_abcd = (state == INIT);
        round_en  = (state == ROUND);
        add_en    = (state == FINAL);
        done      = (state == DONE);
        iv_sel    = (state == IDLE) ? first_blk : iv_flag;
        cnt       = cnt_q;
        fsel      = cnt_q[5:4];
    end

    // Index arithmetic is mod 16, so only the low nibble of cnt matters.
    always_comb begin
        cnt_lo = cnt_q[3:0];
        g      = '0;
        unique case (cnt_q[5:4])
            2'd0: g = cnt_lo;
            2'd1: g = cnt_lo * 4'd5 + 4'd1;
            2'd2: g = cnt_lo * 4'd3 + 4'd5;
            2'd3: g = cnt_lo * 4'd7;
            default: g = '0;
        endcase
    end

endmodule
